// File: rtl/bit32_demux1to3.sv
// ---------------------------------------------------------------------------
// bit32_demux1to3
//
// Registered 1-to-3 demultiplexer with valid/ready handshaking. One input
// word plus a 2-bit select is routed to exactly one of three output
// channels. Each channel owns a one-entry holding register (data + full
// flag) and a wrapping delivered-word counter.
//
// Select encoding (shared with the 3-to-1 selector):
//   00 -> ch1, 01 -> ch2, 1x -> ch3 (in_sel[1] wins)
//
// Ports
//   clk                 single clock, all state on rising edge
//   rst_n               synchronous active-low reset
//   in_data [WIDTH]     word to distribute
//   in_sel  [2]         destination select
//   in_valid            in_data / in_sel valid
//   in_ready            word accepted this cycle (combinational)
//   out1/2/3_data       channel data, stable while valid and not accepted
//   out_valid [3]       per-channel valid, bit0 = ch1 .. bit2 = ch3
//   out_ready [3]       per-channel downstream ready, same order
//   cnt1/2/3  [CNT_W]   delivered-word count per channel (wraps)
// ---------------------------------------------------------------------------
module bit32_demux1to3 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       dest_oh;
  logic [2:0]       full_vec;
  logic             accept;
  logic [WIDTH-1:0] data_bus [3];
  logic [CNT_W-1:0] cnt_bus  [3];

  // One-hot destination; in_sel[1] takes priority so 10 and 11 both map to ch3.
  always_comb begin
    dest_oh = 3'b001;
    if (in_sel[1]) begin
      dest_oh = 3'b100;
    end else if (in_sel[0]) begin
      dest_oh = 3'b010;
    end
  end

  // The selected slot can take a word if it is empty, or if it is being
  // drained on this same edge (keeps full throughput with no bubble).
  assign in_ready = |(dest_oh & (~full_vec | out_ready));
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic             full_reg;
      logic             full_next;
      logic [WIDTH-1:0] data_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             fill;
      logic             deliver;

      assign fill    = accept & dest_oh[gi];
      assign deliver = full_reg & out_ready[gi];

      // A fill wins over a drain, so simultaneous drain+fill keeps the slot full.
      assign full_next = fill | (full_reg & ~deliver);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          full_reg <= 1'b0;
          data_reg <= '0;
          cnt_reg  <= '0;
        end else begin
          full_reg <= full_next;
          if (fill) begin
            data_reg <= in_data;
          end
          if (deliver) begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
      end

      assign full_vec[gi] = full_reg;
      assign data_bus[gi] = data_reg;
      assign cnt_bus[gi]  = cnt_reg;
    end
  endgenerate

  assign out_valid = full_vec;
  assign out1_data = data_bus[0];
  assign out2_data = data_bus[1];
  assign out3_data = data_bus[2];
  assign cnt1      = cnt_bus[0];
  assign cnt2      = cnt_bus[1];
  assign cnt3      = cnt_bus[2];

endmodule
